// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the CPU load/store stage and the data memory controller.
// The master issues valid/ready requests; the slave answers with a one-cycle response pulse.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Flip-flop data memory with registered responses, atomic fetch-and-add and a clear sweep.
// The preload image is restored on reset, which is why the array cannot be a RAM macro.
module data_mem_ctrl #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int INIT_N = 5,
  parameter logic [INIT_N*DATA_W-1:0] INIT_VEC =
    {DATA_W'(3), DATA_W'(0), DATA_W'(0), DATA_W'(7), DATA_W'(5)}
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_ctrl_if.slave       io_bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Zero-extended image so every word index is a legal slice during reset.
  localparam logic [DEPTH*DATA_W-1:0] INIT_FULL = (DEPTH*DATA_W)'(INIT_VEC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RMW, S_CLEAR} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ADD, OP_CLEAR} op_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_old;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_busy;

  logic              w_accept;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign io_bus.req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept         = io_bus.req_valid && io_bus.req_ready;
  assign w_in_range       = addr_ok(io_bus.req_addr);
  assign w_idx            = io_bus.req_addr[IDX_W-1:0];

  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.busy      = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_old       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_FULL[i*DATA_W +: DATA_W];
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op_e'(io_bus.req_op) == OP_CLEAR) begin
              r_ptr   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_CLEAR;
            end else if (!w_in_range) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
            end else begin
              case (op_e'(io_bus.req_op))
                OP_READ: begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_data  <= r_mem[w_idx];
                end
                OP_WRITE: begin
                  r_mem[w_idx] <= io_bus.req_wdata;
                  r_rsp_valid  <= 1'b1;
                  r_rsp_err    <= 1'b0;
                  r_rsp_data   <= io_bus.req_wdata;
                end
                default: begin
                  r_addr  <= w_idx;
                  r_wdata <= io_bus.req_wdata;
                  r_old   <= r_mem[w_idx];
                  r_busy  <= 1'b1;
                  r_state <= S_RMW;
                end
              endcase
            end
          end
        end
        S_RMW: begin
          r_mem[r_addr] <= add_wrap(r_old, r_wdata);
          r_rsp_valid   <= 1'b1;
          r_rsp_err     <= 1'b0;
          r_rsp_data    <= r_old;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        S_CLEAR: begin
          // One word per cycle; the response lands on the edge that writes the last word.
          r_mem[r_ptr] <= '0;
          if (r_ptr == LAST_IDX) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: preload, read/write, fetch-and-add wrap, range errors,
// clear sweep timing and reset in the middle of a clear.
module tb_data_mem_ctrl;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 5;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  data_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (16),
    .INIT_N (5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [DATA_W-1:0] data, input logic err);
    check({tag, "_vld"}, bus.rsp_valid, 1);
    check({tag, "_data"}, bus.rsp_data, data);
    check({tag, "_err"}, bus.rsp_err, err);
  endtask

  task automatic read_expect(input string tag, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
    req(2'b00, addr, '0);
    step();
    idle();
    expect_rsp(tag, data, 1'b0);
  endtask

  initial begin
    int busy_cnt;
    int pulses;
    int rsp_at;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", bus.req_ready, 0);
    check("rst_rsp_vld", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    #1;
    check("rel_ready", bus.req_ready, 1);
    @(negedge clk);

    // Preload readback, back-to-back
    req(2'b00, 5'd0, '0); step(); expect_rsp("rd0", 19'd5, 1'b0);
    req(2'b00, 5'd1, '0); step(); expect_rsp("rd1", 19'd7, 1'b0);
    req(2'b00, 5'd4, '0); step(); expect_rsp("rd4", 19'd3, 1'b0);
    req(2'b00, 5'd5, '0); step(); expect_rsp("rd5", 19'd0, 1'b0);
    idle(); step();
    check("b2b_done_vld", bus.rsp_valid, 0);

    // Write then immediate read of the same word
    req(2'b01, 5'd3, 19'h7FFFF); step(); expect_rsp("wr3", 19'h7FFFF, 1'b0);
    req(2'b00, 5'd3, '0); step(); expect_rsp("rd3_new", 19'h7FFFF, 1'b0);
    idle(); step();

    // Fetch-and-add with wrap; a read held during RMW is accepted after it
    req(2'b10, 5'd0, 19'h7FFFE); step();
    req(2'b00, 5'd0, '0);
    check("rmw_ready", bus.req_ready, 0);
    check("rmw_busy", bus.busy, 1);
    check("rmw_no_rsp", bus.rsp_valid, 0);
    step();
    expect_rsp("add0_old", 19'd5, 1'b0);
    check("rmw_ready_back", bus.req_ready, 1);
    check("rmw_busy_clr", bus.busy, 0);
    step(); idle();
    expect_rsp("rd0_sum", 19'd3, 1'b0);
    step();

    // Out-of-range requests
    req(2'b00, 5'd20, '0); step(); expect_rsp("rd20", 19'd0, 1'b1);
    req(2'b01, 5'd20, 19'd123); step(); expect_rsp("wr20", 19'd0, 1'b1);
    req(2'b10, 5'd31, 19'd1); step(); idle();
    expect_rsp("add31", 19'd0, 1'b1);
    check("add31_ready", bus.req_ready, 1);
    check("add31_busy", bus.busy, 0);
    read_expect("rd4_alias", 5'd4, 19'd3);
    step();

    // Clear sweep timing
    req(2'b11, 5'd7, '0); step(); idle();
    busy_cnt = 0; pulses = 0; rsp_at = 0;
    for (int k = 1; k <= 30; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.rsp_valid) begin
        pulses++;
        rsp_at = k;
        check("clr_rsp_data", bus.rsp_data, 0);
        check("clr_rsp_err", bus.rsp_err, 0);
      end
      if (k == 5) check("clr_ready", bus.req_ready, 0);
      step();
    end
    check("clr_busy_cycles", busy_cnt, 16);
    check("clr_pulses", pulses, 1);
    check("clr_rsp_at", rsp_at, 17);
    read_expect("clr_rd0", 5'd0, 19'd0);
    read_expect("clr_rd4", 5'd4, 19'd0);
    read_expect("clr_rd3", 5'd3, 19'd0);
    step();

    // Reset in the middle of a clear (ptr = 7)
    req(2'b11, 5'd0, '0); step(); idle();
    for (int k = 0; k < 7; k++) step();
    check("mid_clr_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("abort_vld", bus.rsp_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_ready", bus.req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.rsp_valid) pulses++;
      step();
    end
    check("abort_no_rsp", pulses, 0);
    read_expect("rst_rd0", 5'd0, 19'd5);
    read_expect("rst_rd10", 5'd10, 19'd0);
    read_expect("rst_rd1", 5'd1, 19'd7);
    read_expect("rst_rd3", 5'd3, 19'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
